// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two requester handshakes, their responses, and the
// single-port data memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [1:0]        req0_size;
    logic              req0_unsigned;
    logic [ADDR_W-1:0] req0_addr;
    logic [31:0]       req0_wdata;
    logic              rsp0_valid;
    logic [31:0]       rsp0_rdata;
    logic              rsp0_err;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [1:0]        req1_size;
    logic              req1_unsigned;
    logic [ADDR_W-1:0] req1_addr;
    logic [31:0]       req1_wdata;
    logic              rsp1_valid;
    logic [31:0]       rsp1_rdata;
    logic              rsp1_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_we, req0_size, req0_unsigned, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_size, req1_unsigned, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    // Requesters plus memory.
    modport master (
        output req0_valid, req0_we, req0_size, req0_unsigned, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_size, req1_unsigned, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between two requesters;
// sub-word loads extract/extend a lane, sub-word stores read-modify-write.
module dmem_arbiter #(
    parameter int DEPTH_BYTES = 64,
    parameter int ADDR_W      = 64
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(DEPTH_BYTES - 4);

    logic [1:0]        state;
    logic              last_grant;
    logic              owner;
    logic              op_we;
    logic              op_uns;
    logic [1:0]        op_size;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_data;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    logic              any_valid;
    logic              grant;
    logic              accept;
    logic              sel_we;
    logic              sel_uns;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              fault;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    // Contention goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
        else                                  grant = bus.req1_valid;
        accept    = (state == S_IDLE) && rst && any_valid;
        sel_we    = grant ? bus.req1_we       : bus.req0_we;
        sel_uns   = grant ? bus.req1_unsigned : bus.req0_unsigned;
        sel_size  = grant ? bus.req1_size     : bus.req0_size;
        sel_addr  = grant ? bus.req1_addr     : bus.req0_addr;
        sel_wdata = grant ? bus.req1_wdata    : bus.req0_wdata;
        fault = (sel_size == 2'b11)
             || (sel_size == 2'b01 && sel_addr[0])
             || (sel_size == 2'b10 && sel_addr[1:0] != 2'b00)
             || ({sel_addr[ADDR_W-1:2], 2'b00} > LAST_BASE);
    end

    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept && grant;

    // Lane selection off the returned word: loads extend it, stores overwrite it.
    always_comb begin
        lane_b = bus.mem_rdata[{op_addr[1:0], 3'b000} +: 8];
        lane_h = bus.mem_rdata[{op_addr[1], 4'b0000} +: 16];
        case (op_size)
            2'b00:   load_val = {{24{~op_uns & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{~op_uns & lane_h[15]}}, lane_h};
            default: load_val = bus.mem_rdata;
        endcase
        merged = bus.mem_rdata;
        if (op_size == 2'b00) merged[{op_addr[1:0], 3'b000} +: 8]  = op_data[7:0];
        else                  merged[{op_addr[1], 4'b0000} +: 16] = op_data[15:0];
    end

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_we      <= 1'b0;
            op_uns     <= 1'b0;
            op_size    <= 2'b00;
            op_addr    <= '0;
            op_data    <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (any_valid) begin
                    owner      <= grant;
                    last_grant <= grant;
                    op_we      <= sel_we;
                    op_uns     <= sel_uns;
                    op_size    <= sel_size;
                    op_addr    <= sel_addr;
                    op_data    <= sel_wdata;
                    rsp_data   <= '0;
                    rsp_err    <= fault;
                    if (fault)                                state <= S_RESP;
                    else if (!sel_we || sel_size != 2'b10)    state <= S_READ;
                    else                                      state <= S_WRITE;
                end
                S_READ: begin
                    if (op_we) begin
                        op_data <= merged;
                        state   <= S_WRITE;
                    end else begin
                        rsp_data <= load_val;
                        state    <= S_RESP;
                    end
                end
                S_WRITE: state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_re     = (state == S_READ);
    assign bus.mem_we     = (state == S_WRITE);
    assign bus.mem_addr   = (bus.mem_re || bus.mem_we) ? {op_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wdata  = bus.mem_we ? op_data : '0;

    assign bus.rsp0_valid = (state == S_RESP) && !owner;
    assign bus.rsp1_valid = (state == S_RESP) && owner;
    assign bus.rsp0_rdata = bus.rsp0_valid ? rsp_data : '0;
    assign bus.rsp1_rdata = bus.rsp1_valid ? rsp_data : '0;
    assign bus.rsp0_err   = bus.rsp0_valid && rsp_err;
    assign bus.rsp1_err   = bus.rsp1_valid && rsp_err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised two-requester bench for dmem_arbiter against a byte-level transaction
// model, plus directed accesses with hand-computed results.
module tb_dmem_arbiter;
    localparam int DEPTH = 64;
    localparam int AW    = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW)) bus ();
    dmem_arbiter #(.DEPTH_BYTES(DEPTH), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Requester drive, indexed by port
    logic          d_valid [2];
    logic          d_we    [2];
    logic          d_uns   [2];
    logic [1:0]    d_size  [2];
    logic [AW-1:0] d_addr  [2];
    logic [31:0]   d_wdata [2];

    assign bus.req0_valid    = d_valid[0];
    assign bus.req0_we       = d_we[0];
    assign bus.req0_unsigned = d_uns[0];
    assign bus.req0_size     = d_size[0];
    assign bus.req0_addr     = d_addr[0];
    assign bus.req0_wdata    = d_wdata[0];
    assign bus.req1_valid    = d_valid[1];
    assign bus.req1_we       = d_we[1];
    assign bus.req1_unsigned = d_uns[1];
    assign bus.req1_size     = d_size[1];
    assign bus.req1_addr     = d_addr[1];
    assign bus.req1_wdata    = d_wdata[1];

    // Data memory: combinational read, write on the clock edge
    logic [7:0] mem [DEPTH];
    logic       mem_init;
    logic [5:0] ma;
    assign ma = bus.mem_addr[5:0];
    assign bus.mem_rdata = {mem[ma + 6'd3], mem[ma + 6'd2], mem[ma + 6'd1], mem[ma]};
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
        end else if (bus.mem_we) begin
            for (int i = 0; i < 4; i++) mem[ma + 6'(i)] <= bus.mem_wdata[8*i +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Transaction model: one outstanding access, expected events scheduled by cycle
    logic [7:0]  ref_mem [DEPTH];
    logic        m_last;
    logic        m_owner;
    int          m_re_cyc  = -1;
    int          m_we_cyc  = -1;
    int          m_rsp_cyc = -1;
    logic [63:0] m_base;
    logic [31:0] m_wword;
    logic [31:0] m_rdata;
    logic        m_err;
    int          re_cnt = 0, we_cnt = 0, rsp_cnt = 0;
    int          last_re_cyc = -1, last_we_cyc = -1;
    logic [31:0] last_we_data;

    always @(negedge clk) begin : model
        logic        idle, g, e_re, e_we, e_rsp, w, u;
        logic [1:0]  sz;
        logic [63:0] a;
        logic [31:0] wd, v, mask;
        int          nb, idx, bidx;
        logic [7:0]  tmp [4];
        if (!rst) begin
            check("rst_ready0", bus.req0_ready, 0);
            check("rst_ready1", bus.req1_ready, 0);
            check("rst_rsp0_valid", bus.rsp0_valid, 0);
            check("rst_rsp1_valid", bus.rsp1_valid, 0);
            check("rst_rsp0_rdata", bus.rsp0_rdata, 0);
            check("rst_rsp1_rdata", bus.rsp1_rdata, 0);
            check("rst_rsp_err", {bus.rsp1_err, bus.rsp0_err}, 0);
            check("rst_mem_re", bus.mem_re, 0);
            check("rst_mem_we", bus.mem_we, 0);
            check("rst_mem_addr", bus.mem_addr, 0);
            check("rst_mem_wdata", bus.mem_wdata, 0);
            m_last = 1'b1;
            m_re_cyc = -1; m_we_cyc = -1; m_rsp_cyc = -1;
        end else begin
            idle  = (cyc > m_rsp_cyc);
            g     = (d_valid[0] && d_valid[1]) ? !m_last : d_valid[1];
            e_re  = (cyc == m_re_cyc);
            e_we  = (cyc == m_we_cyc);
            e_rsp = (cyc == m_rsp_cyc);
            check("ready0", bus.req0_ready, idle && (d_valid[0] || d_valid[1]) && !g);
            check("ready1", bus.req1_ready, idle && (d_valid[0] || d_valid[1]) && g);
            check("mem_re", bus.mem_re, e_re);
            check("mem_we", bus.mem_we, e_we);
            check("mem_addr", bus.mem_addr, (e_re || e_we) ? m_base : 64'd0);
            if (e_we) check("mem_wdata", bus.mem_wdata, m_wword);
            check("rsp0_valid", bus.rsp0_valid, e_rsp && !m_owner);
            check("rsp1_valid", bus.rsp1_valid, e_rsp && m_owner);
            check("rsp0_rdata", bus.rsp0_rdata, (e_rsp && !m_owner) ? m_rdata : 32'd0);
            check("rsp1_rdata", bus.rsp1_rdata, (e_rsp && m_owner) ? m_rdata : 32'd0);
            check("rsp0_err", bus.rsp0_err, e_rsp && !m_owner && m_err);
            check("rsp1_err", bus.rsp1_err, e_rsp && m_owner && m_err);
            if (bus.mem_re) begin re_cnt++; last_re_cyc = cyc; end
            if (bus.mem_we) begin we_cnt++; last_we_cyc = cyc; last_we_data = bus.mem_wdata; end
            if (bus.rsp0_valid || bus.rsp1_valid) rsp_cnt++;
            if (e_we) begin
                for (int i = 0; i < 4; i++) ref_mem[int'(m_base[5:0]) + i] = m_wword[8*i +: 8];
            end
            if (idle && (d_valid[0] || d_valid[1])) begin
                a  = d_addr[int'(g)];
                sz = d_size[int'(g)];
                w  = d_we[int'(g)];
                u  = d_uns[int'(g)];
                wd = d_wdata[int'(g)];
                nb = (sz == 2'd3) ? 4 : (1 << sz);
                m_last  = g;
                m_owner = g;
                m_base  = a - (a % 64'd4);
                m_rdata = '0;
                m_err   = (sz == 2'd3) || (a % 64'(nb) != 0) || (m_base + 64'd3 > 64'(DEPTH - 1));
                m_re_cyc = -1; m_we_cyc = -1;
                idx  = int'(a[5:0]);
                bidx = int'(m_base[5:0]);
                if (m_err) begin
                    m_rsp_cyc = cyc + 1;
                end else if (!w) begin
                    v = '0;
                    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[idx + i];
                    mask = (nb == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
                    if (!u && nb < 4 && v[8*nb-1]) v = v | ~mask;
                    m_rdata   = v;
                    m_re_cyc  = cyc + 1;
                    m_rsp_cyc = cyc + 2;
                end else if (nb == 4) begin
                    m_wword   = wd;
                    m_we_cyc  = cyc + 1;
                    m_rsp_cyc = cyc + 2;
                end else begin
                    for (int i = 0; i < 4; i++) tmp[i] = ref_mem[bidx + i];
                    for (int i = 0; i < nb; i++) tmp[idx - bidx + i] = wd[8*i +: 8];
                    m_wword   = {tmp[3], tmp[2], tmp[1], tmp[0]};
                    m_re_cyc  = cyc + 1;
                    m_we_cyc  = cyc + 2;
                    m_rsp_cyc = cyc + 3;
                end
            end
        end
        if (mem_init) for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i);
    end

    function automatic logic ready_of(input int p);
        return (p == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [63:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat, output int t_acc);
        logic got;
        @(posedge clk); #1;
        d_we[p] = we; d_size[p] = sz; d_uns[p] = uns; d_addr[p] = a; d_wdata[p] = wd;
        d_valid[p] = 1'b1;
        got = 1'b0; t_acc = -1; rd = '0; er = 1'b0; lat = -1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (ready_of(p)) begin got = 1'b1; t_acc = cyc; end
        end
        @(posedge clk); #1;
        d_valid[p] = 1'b0;
        if (got) begin
            got = 1'b0;
            for (int n = 0; n < 10 && !got; n++) begin
                @(negedge clk);
                if (p == 0 ? bus.rsp0_valid : bus.rsp1_valid) begin
                    got = 1'b1;
                    rd  = (p == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
                    er  = (p == 0) ? bus.rsp0_err : bus.rsp1_err;
                    lat = cyc - t_acc;
                end
            end
        end
    endtask

    task automatic req_chk(input string name, input int p, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [63:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                           output int t_acc);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(p, we, sz, uns, a, wd, rd, er, lat, t_acc);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, er, exp_err);
        check({name, "_latency"}, lat, exp_lat);
    endtask

    int order[$];

    task automatic watch_grants(input int n);
        order.delete();
        for (int k = 0; k < 100 && order.size() < n; k++) begin
            @(negedge clk);
            if (bus.req0_ready) order.push_back(0);
            if (bus.req1_ready) order.push_back(1);
        end
        @(posedge clk); #1;
        d_valid[0] = 1'b0;
        d_valid[1] = 1'b0;
    endtask

    task automatic new_req(input int p);
        int r;
        r = $urandom_range(0, 9);
        d_size[p]  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        d_we[p]    = 1'($urandom_range(0, 1));
        d_uns[p]   = 1'($urandom_range(0, 1));
        d_wdata[p] = $urandom;
        d_addr[p]  = ($urandom_range(0, 11) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 67));
        d_valid[p] = 1'b1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int t, re_snap, we_snap, rsp_snap;
        logic r0, r1, rdy;
        for (int p = 0; p < 2; p++) begin
            d_valid[p] = 1'b0; d_we[p] = 1'b0; d_uns[p] = 1'b0;
            d_size[p] = 2'd2; d_addr[p] = '0; d_wdata[p] = '0;
        end
        d_addr[1] = 64'd4;
        d_valid[0] = 1'b1;
        d_valid[1] = 1'b1;
        mem_init = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        rst = 1'b1;

        // Both word loads pending straight out of reset: strict alternation, req0 first
        watch_grants(4);
        check("t4_grant_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) check($sformatf("t4_grant%0d", i), order[i], i % 2);
        repeat (4) @(posedge clk);

        req_chk("t1_lw8", 0, 1'b0, 2'd2, 1'b0, 64'd8, 32'd0, 32'h0B0A_0908, 1'b0, 2, t);

        req_chk("t2_sb5", 0, 1'b1, 2'd0, 1'b0, 64'd5, 32'h0000_00FF, 32'd0, 1'b0, 3, t);
        check("t2_re_offset", last_re_cyc - t, 1);
        check("t2_we_offset", last_we_cyc - t, 2);
        check("t2_we_data", last_we_data, 32'h0706_FF04);
        req_chk("t2_lw4", 0, 1'b0, 2'd2, 1'b0, 64'd4, 32'd0, 32'h0706_FF04, 1'b0, 2, t);

        req_chk("t3_lb5", 0, 1'b0, 2'd0, 1'b0, 64'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 2, t);
        req_chk("t3_lbu5", 1, 1'b0, 2'd0, 1'b1, 64'd5, 32'd0, 32'h0000_00FF, 1'b0, 2, t);
        req_chk("t3_lh6", 0, 1'b0, 2'd1, 1'b0, 64'd6, 32'd0, 32'h0000_0706, 1'b0, 2, t);
        req_chk("t3_sh6", 0, 1'b1, 2'd1, 1'b0, 64'd6, 32'h0000_BEEF, 32'd0, 1'b0, 3, t);
        req_chk("t3_lw4", 1, 1'b0, 2'd2, 1'b0, 64'd4, 32'd0, 32'hBEEF_FF04, 1'b0, 2, t);

        re_snap = re_cnt;
        we_snap = we_cnt;
        req_chk("t5_lw62", 0, 1'b0, 2'd2, 1'b0, 64'd62, 32'd0, 32'd0, 1'b1, 1, t);
        req_chk("t5_lh3", 0, 1'b0, 2'd1, 1'b0, 64'd3, 32'd0, 32'd0, 1'b1, 1, t);
        req_chk("t5_lw64", 0, 1'b0, 2'd2, 1'b0, 64'd64, 32'd0, 32'd0, 1'b1, 1, t);
        req_chk("t5_size3", 1, 1'b1, 2'd3, 1'b0, 64'd0, 32'h1234_5678, 32'd0, 1'b1, 1, t);
        check("t5_no_mem_re", re_cnt - re_snap, 0);
        check("t5_no_mem_we", we_cnt - we_snap, 0);

        // Reset lands in the READ half of a byte store
        @(posedge clk); #1; mem_init = 1'b1;
        @(posedge clk); #1; mem_init = 1'b0;
        d_we[0] = 1'b1; d_size[0] = 2'd0; d_uns[0] = 1'b0; d_addr[0] = 64'd5; d_wdata[0] = 32'hFF;
        d_valid[0] = 1'b1;
        t = -1;
        for (int n = 0; n < 40 && t < 0; n++) begin
            @(negedge clk);
            if (bus.req0_ready) t = cyc;
        end
        check("t6_accepted", t >= 0, 1);
        @(posedge clk); #1;
        d_valid[0] = 1'b0;
        check("t6_in_read", bus.mem_re, 1);
        we_snap  = we_cnt;
        rsp_snap = rsp_cnt;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("t6_no_mem_we", we_cnt - we_snap, 0);
        check("t6_no_rsp", rsp_cnt - rsp_snap, 0);
        check("t6_mem5", mem[5], 8'h05);
        d_we[0] = 1'b0; d_size[0] = 2'd2; d_addr[0] = 64'd0;
        d_we[1] = 1'b0; d_size[1] = 2'd2; d_addr[1] = 64'd4;
        d_valid[0] = 1'b1;
        d_valid[1] = 1'b1;
        watch_grants(2);
        check("t6_grant_count", order.size(), 2);
        if (order.size() > 0) check("t6_first_grant", order[0], 0);
        repeat (4) @(posedge clk);

        // Random traffic on both ports, including withdrawals and faulting requests
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            r0 = bus.req0_ready;
            r1 = bus.req1_ready;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                rdy = (p == 0) ? r0 : r1;
                if (d_valid[p] && rdy) d_valid[p] = 1'b0;
                else if (d_valid[p] && $urandom_range(0, 40) == 0) d_valid[p] = 1'b0;
                if (!d_valid[p] && $urandom_range(0, 2) == 0) new_req(p);
            end
        end
        d_valid[0] = 1'b0;
        d_valid[1] = 1'b0;
        repeat (8) @(posedge clk);
        for (int i = 0; i < DEPTH; i++) check($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
